// File: rtl/fraction_multiplication_pkg.sv
// Shared types and width helpers for the sequential signed-fraction multiplier.
package fraction_multiplication_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   function automatic int pw_of(input int n);
      return 2 * n - 1;
   endfunction

   function automatic int aw_of(input int n);
      return n + 1;
   endfunction

   // Largest positive Q1.(2n-2) value; stands in for the unrepresentable -1 x -1.
   function automatic logic [63:0] sat_of(input int n);
      return (64'd1 << (2 * n - 2)) - 64'd1;
   endfunction

endpackage

// File: rtl/frac_addsub.sv
// Guarded add/subtract of the sign-extended multiplicand into the accumulator.
module frac_addsub
   import fraction_multiplication_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N:0]   a,
   input  logic [N-1:0] c,
   input  logic         en,
   input  logic         sub,
   output logic [N:0]   sum
);

   logic [N:0] ext;

   assign ext = {c[N-1], c};

   always_comb begin
      sum = a;
      if (en) begin
         sum = sub ? (a - ext) : (a + ext);
      end
   end

endmodule

// File: rtl/fraction_multiplication.sv
// Add-and-shift multiplier for two's-complement Q1.(N-1) fractions,
// one multiplier bit per cycle, subtracting on the sign bit.
module fraction_multiplication
   import fraction_multiplication_pkg::*;
#(
   parameter int N = 4
) (
   input  logic                 CLK,
   input  logic                 Rst,
   input  logic                 St,
   input  logic [N-1:0]         Mplier,
   input  logic [N-1:0]         Mcand,
   output logic [2*N-2:0]       Product,
   output logic                 Done
);

   localparam int PW = pw_of(N);
   localparam int AW = aw_of(N);
   localparam int KW = $clog2(N);
   localparam logic [PW-1:0] SAT  = PW'(sat_of(N));
   localparam logic [N-1:0]  NEG1 = {1'b1, {(N-1){1'b0}}};
   localparam logic [KW-1:0] LAST = KW'(N - 1);

   state_t        state;
   logic [AW-1:0] a;
   logic [N-1:0]  b;
   logic [N-1:0]  c;
   logic [KW-1:0] k;
   logic          sat;

   logic [AW-1:0] sum;
   logic [AW-1:0] a_nxt;
   logic [N-1:0]  b_nxt;

   frac_addsub #(
      .N (N)
   ) u_addsub (
      .a   (a),
      .c   (c),
      .en  (b[0]),
      .sub (k == LAST),
      .sum (sum)
   );

   // Arithmetic right shift of {sum, b}, replicating the guard sign bit.
   assign a_nxt = {sum[AW-1], sum[AW-1:1]};
   assign b_nxt = {sum[0], b[N-1:1]};

   always_ff @(posedge CLK) begin
      if (Rst) begin
         state   <= IDLE;
         a       <= '0;
         b       <= '0;
         c       <= '0;
         k       <= '0;
         sat     <= 1'b0;
         Product <= '0;
         Done    <= 1'b0;
      end else begin
         Done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (St) begin
                  c     <= Mcand;
                  a     <= '0;
                  b     <= Mplier;
                  k     <= '0;
                  sat   <= (Mplier == NEG1) && (Mcand == NEG1);
                  state <= CALC;
               end
            end
            CALC: begin
               a <= a_nxt;
               b <= b_nxt;
               k <= k + KW'(1);
               if (k == LAST) begin
                  state <= DONE;
               end
            end
            DONE: begin
               Product <= sat ? SAT : {a[N-2:0], b};
               Done    <= 1'b1;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fraction_multiplication.sv
// Self-checking bench: directed and random operands against an integer model.
module tb_fraction_multiplication;

   localparam int N  = 4;
   localparam int PW = 2 * N - 1;

   logic          CLK;
   logic          Rst;
   logic          St;
   logic [N-1:0]  Mplier;
   logic [N-1:0]  Mcand;
   logic [PW-1:0] Product;
   logic          Done;

   int errors;
   int checks;

   fraction_multiplication #(
      .N (N)
   ) dut (
      .CLK     (CLK),
      .Rst     (Rst),
      .St      (St),
      .Mplier  (Mplier),
      .Mcand   (Mcand),
      .Product (Product),
      .Done    (Done)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Exact integer product of the two fractions, scaled by 2^(2N-2).
   function automatic logic [PW-1:0] ref_prod(input logic [N-1:0] x,
                                              input logic [N-1:0] y);
      int xi;
      int yi;
      int p;
      logic [31:0] pv;
      xi = int'($signed(x));
      yi = int'($signed(y));
      p  = xi * yi;
      if (p >= (1 << (2 * N - 2))) begin
         return {1'b0, {(PW-1){1'b1}}};
      end
      pv = p;
      return pv[PW-1:0];
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Runs one operation, checking latency, pulse width and product.
   task automatic run_op(input logic [N-1:0] mp, input logic [N-1:0] mc,
                         input string tag);
      logic [PW-1:0] exp;
      int lat;
      exp = ref_prod(mp, mc);
      @(negedge CLK);
      Mplier = mp;
      Mcand  = mc;
      St     = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      St     = 1'b0;
      Mplier = N'($urandom);
      Mcand  = N'($urandom);
      lat = 0;
      while (lat < 20) begin
         @(posedge CLK);
         #1;
         lat++;
         if (Done) break;
      end
      check({tag, "_lat"}, lat, 5);
      check({tag, "_prod"}, int'(Product), int'(exp));
      @(posedge CLK);
      #1;
      check({tag, "_pulse"}, int'(Done), 0);
      repeat (4) @(posedge CLK);
   endtask

   initial begin
      int pulses;
      logic [PW-1:0] held;
      errors = 0;
      checks = 0;
      Rst    = 1'b1;
      St     = 1'b0;
      Mplier = '0;
      Mcand  = '0;

      repeat (2) @(posedge CLK);
      #1;
      check("rst_prod", int'(Product), 0);
      check("rst_done", int'(Done), 0);
      @(negedge CLK);
      Rst = 1'b0;
      pulses = 0;
      repeat (6) begin
         @(posedge CLK);
         #1;
         if (Done) pulses++;
      end
      check("idle_no_done", pulses, 0);

      run_op(4'b1111, 4'b1111, "m1_8sq");
      run_op(4'b1001, 4'b0101, "n7x5");
      run_op(4'b1011, 4'b0001, "n5x1");
      run_op(4'b0100, 4'b0100, "q_sq");
      run_op(4'b0000, 4'b0000, "z0");
      run_op(4'b0000, 4'b0001, "z1");
      run_op(4'b0000, 4'b1010, "z2");
      run_op(4'b1000, 4'b1000, "sat");
      run_op(4'b0111, 4'b1000, "p7xm1");

      held = Product;
      repeat (10) @(posedge CLK);
      #1;
      check("hold", int'(Product), int'(held));

      // A second St during CALC must be ignored.
      @(negedge CLK);
      Mplier = 4'b0011;
      Mcand  = 4'b0101;
      St     = 1'b1;
      @(negedge CLK);
      St = 1'b0;
      @(negedge CLK);
      Mplier = 4'b1110;
      Mcand  = 4'b0111;
      St     = 1'b1;
      @(negedge CLK);
      St = 1'b0;
      pulses = 0;
      repeat (14) begin
         @(posedge CLK);
         #1;
         if (Done) pulses++;
      end
      check("restart_pulses", pulses, 1);
      check("restart_prod", int'(Product),
            int'(ref_prod(4'b0011, 4'b0101)));

      // Reset during CALC aborts with no Done pulse.
      @(negedge CLK);
      Mplier = 4'b0110;
      Mcand  = 4'b0110;
      St     = 1'b1;
      @(negedge CLK);
      St = 1'b0;
      @(negedge CLK);
      Rst = 1'b1;
      @(negedge CLK);
      Rst = 1'b0;
      check("abort_prod", int'(Product), 0);
      pulses = 0;
      repeat (10) begin
         @(posedge CLK);
         #1;
         if (Done) pulses++;
      end
      check("abort_no_done", pulses, 0);
      run_op(4'b0110, 4'b1101, "after_abort");

      for (int i = 0; i < 24; i++) begin
         run_op(N'($urandom_range(0, 15)), N'($urandom_range(0, 15)),
                "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
